ising_run_ctrl: RTL and testbench

//  Multi-run controller for the oscillator array. Repeatedly resets the array,

---
 rtl/ising_run_ctrl_if.sv | 32 +++
 rtl/ising_run_ctrl.sv | 200 ++++++++++++++++++++
 tb/tb_ising_run_ctrl.sv | 217 +++++++++++++++++++++
 3 files changed

// File: rtl/ising_run_ctrl_if.sv
// ============================================================================
//  Module      : ising_run_ctrl_if
//  Description : Host-side control, status and read-back bundle of the
//                oscillator-array multi-run controller.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface ising_run_ctrl_if;
    logic        start;
    logic        abort;
    logic [31:0] num_runs;
    logic [31:0] counter_max;
    logic        busy;
    logic        done;
    logic [31:0] rd_addr;
    logic [31:0] rdata;

    // Host side: issues commands and addresses, observes status and data
    modport master (
        output start, abort, num_runs, counter_max, rd_addr,
        input  busy, done, rdata
    );

    // Controller side
    modport slave (
        input  start, abort, num_runs, counter_max, rd_addr,
        output busy, done, rdata
    );
endinterface

`default_nettype wire

// File: rtl/ising_run_ctrl.sv
// ============================================================================
//  Module      : ising_run_ctrl
//  Description : Multi-run controller for the oscillator array. Holds the
//                array in reset, lets it evolve for a programmed number of
//                cycles, snapshots the synchronised spin outputs into a
//                circular buffer and repeats for a batch of runs.
//  Option      : MAJORITY_VOTE_EN - 3-cycle sample with per-bit majority vote
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module ising_run_ctrl #(
    parameter int N          = 3,
    parameter int DEPTH      = 16,
    parameter int RST_CYCLES = 4
) (
    input  wire logic         clk,
    input  wire logic         rstn,
    ising_run_ctrl_if.slave   host,
    input  wire logic [N-1:0] outputs,
    output logic              ising_rstn
);

    localparam int          AW         = $clog2(DEPTH);
    localparam logic [31:0] c_RST_LAST = 32'(RST_CYCLES - 1);
    localparam logic [31:0] c_DEPTH    = 32'(DEPTH);
`ifdef MAJORITY_VOTE_EN
    localparam logic [31:0] c_SMP_LAST = 32'd2;
`else
    localparam logic [31:0] c_SMP_LAST = 32'd0;
`endif

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_ARST   = 3'd1,
        S_RUN    = 3'd2,
        S_SAMPLE = 3'd3,
        S_DONE   = 3'd4
    } state_t;

    state_t        r_state;
    state_t        w_next;
    logic [31:0]   r_nruns;
    logic [31:0]   r_cmax;
    logic [31:0]   r_cnt;
    logic [31:0]   r_run_cnt;
    logic [31:0]   w_run_cnt_inc;
    logic [AW-1:0] r_wr_ptr;
    logic          r_ovf;
    logic          r_sticky;
    logic          r_busy;
    logic          r_done;
    logic          r_rstn;
    logic          w_busy;
    logic          w_done;
    logic          w_rstn;
    logic          w_accept;
    logic          w_commit;
    logic [N-1:0]  r_sync1;
    logic [N-1:0]  r_sync_q;
    logic [N-1:0]  w_snap;
    logic [N-1:0]  r_buf [DEPTH];
    logic [31:0]   w_rd;
    logic [31:0]   r_rdata;

    // start is only honoured in IDLE; abort is irrelevant there
    assign w_accept      = (r_state == S_IDLE) && host.start;
    // A snapshot is committed on the last SAMPLE cycle unless aborted
    assign w_commit      = (r_state == S_SAMPLE) && (r_cnt == c_SMP_LAST) && !host.abort;
    assign w_run_cnt_inc = (r_run_cnt == 32'hFFFF_FFFF) ? r_run_cnt : r_run_cnt + 32'd1;

    // Two-stage synchroniser for the free-running oscillator outputs
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_sync1  <= '0;
            r_sync_q <= '0;
        end else begin
            r_sync1  <= outputs;
            r_sync_q <= r_sync1;
        end
    end

`ifdef MAJORITY_VOTE_EN
    logic [N-1:0] r_cap0;
    logic [N-1:0] r_cap1;

    // Hold the first two captures of the sample window for the vote
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_cap0 <= '0;
            r_cap1 <= '0;
        end else if (r_state == S_SAMPLE) begin
            if (r_cnt == 32'd0) r_cap0 <= r_sync_q;
            if (r_cnt == 32'd1) r_cap1 <= r_sync_q;
        end
    end

    assign w_snap = (r_cap0 & r_cap1) | (r_cap0 & r_sync_q) | (r_cap1 & r_sync_q);
`else
    assign w_snap = r_sync_q;
`endif

    // FSM state register
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) r_state <= S_IDLE;
        else       r_state <= w_next;
    end

    // Next state and the state-aligned output levels for the next cycle
    always_comb begin
        w_next = r_state;
        if (host.abort && (r_state != S_IDLE)) begin
            w_next = S_IDLE;
        end else begin
            case (r_state)
                S_IDLE:   if (host.start) w_next = (host.num_runs == 32'd0) ? S_DONE : S_ARST;
                S_ARST:   if (r_cnt == c_RST_LAST) w_next = S_RUN;
                S_RUN:    if (r_cnt == r_cmax - 32'd1) w_next = S_SAMPLE;
                S_SAMPLE: if (r_cnt == c_SMP_LAST) w_next = (w_run_cnt_inc == r_nruns) ? S_DONE : S_ARST;
                S_DONE:   w_next = S_IDLE;
                default:  w_next = S_IDLE;
            endcase
        end
        w_rstn = (w_next == S_RUN) || (w_next == S_SAMPLE);
        w_busy = (w_next == S_ARST) || (w_next == S_RUN) || (w_next == S_SAMPLE);
        w_done = (w_next == S_DONE);
    end

    // Registered outputs plus the per-state cycle counter (restarts on entry)
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_rstn <= 1'b0;
            r_busy <= 1'b0;
            r_done <= 1'b0;
            r_cnt  <= '0;
        end else begin
            r_rstn <= w_rstn;
            r_busy <= w_busy;
            r_done <= w_done;
            if ((w_next != r_state) || (r_state == S_IDLE)) r_cnt <= '0;
            else                                             r_cnt <= r_cnt + 32'd1;
        end
    end

    // Batch bookkeeping: parameter latch, write pointer, run count, flags
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_nruns   <= '0;
            r_cmax    <= '0;
            r_run_cnt <= '0;
            r_wr_ptr  <= '0;
            r_ovf     <= 1'b0;
            r_sticky  <= 1'b0;
        end else begin
            if (w_accept) begin
                r_nruns   <= host.num_runs;
                r_cmax    <= (host.counter_max == 32'd0) ? 32'd1 : host.counter_max;
                r_run_cnt <= '0;
                r_wr_ptr  <= '0;
                r_ovf     <= 1'b0;
                r_sticky  <= 1'b0;
            end
            if (w_commit) begin
                r_wr_ptr  <= r_wr_ptr + AW'(1);
                r_run_cnt <= w_run_cnt_inc;
                if (w_run_cnt_inc > c_DEPTH) r_ovf <= 1'b1;
            end
            if (w_done) r_sticky <= 1'b1;
        end
    end

    // Snapshot storage; contents are not reset
    always_ff @(posedge clk) begin
        if (w_commit) r_buf[r_wr_ptr] <= w_snap;
    end

    // Read decode: status word, zero-extended snapshot, or zero
    always_comb begin
        w_rd = '0;
        if (host.rd_addr == 32'd0) begin
            w_rd = {r_busy, r_sticky, r_ovf, 13'b0, r_run_cnt[15:0]};
        end else if (host.rd_addr <= c_DEPTH) begin
            w_rd[N-1:0] = r_buf[AW'(host.rd_addr - 32'd1)];
        end
    end

    // One-cycle registered read data
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) r_rdata <= '0;
        else       r_rdata <= w_rd;
    end

    assign ising_rstn = r_rstn;
    assign host.busy  = r_busy;
    assign host.done  = r_done;
    assign host.rdata = r_rdata;

endmodule

`default_nettype wire

// File: tb/tb_ising_run_ctrl.sv
// ============================================================================
//  Module      : tb_ising_run_ctrl
//  Description : Self-checking bench for ising_run_ctrl. Expected waveforms
//                and buffer contents come from a cycle-schedule model of a
//                batch (run period = reset + run length + sample window).
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_ising_run_ctrl;

    localparam int N     = 3;
    localparam int DEPTH = 16;
    localparam int RSTC  = 4;
`ifdef MAJORITY_VOTE_EN
    localparam int SL = 3;
`else
    localparam int SL = 1;
`endif

    logic         clk = 1'b0;
    logic         rstn = 1'b0;
    logic [N-1:0] outputs = '0;
    logic         ising_rstn;

    ising_run_ctrl_if hif ();

    ising_run_ctrl #(.N(N), .DEPTH(DEPTH), .RST_CYCLES(RSTC)) dut (
        .clk        (clk),
        .rstn       (rstn),
        .host       (hif),
        .outputs    (outputs),
        .ising_rstn (ising_rstn)
    );

    always #5 clk = ~clk;

    int           n_cmp = 0;
    int           n_bad = 0;
    logic [N-1:0] m_buf   [DEPTH];
    bit           m_valid [DEPTH];
    int           m_runs   = 0;
    bit           m_ovf    = 1'b0;
    bit           m_sticky = 1'b0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic rd(input logic [31:0] a, input logic [31:0] e, input string tag);
        hif.rd_addr = a;
        tick();
        chk(tag, hif.rdata, e);
    endtask

    function automatic logic [31:0] status_word();
        logic [31:0] s;
        s = {1'b0, m_sticky, m_ovf, 13'b0, 16'(m_runs)};
        return s;
    endfunction

    task automatic check_buf(input string tag);
        for (int i = 1; i <= DEPTH; i++)
            if (m_valid[i-1]) rd(32'(i), 32'(m_buf[i-1]), $sformatf("%s_buf%0d", tag, i));
        rd(32'(DEPTH + 1), 32'd0, {tag, "_oob"});
        rd(32'hFFFF_FFFF, 32'd0, {tag, "_far"});
        rd(32'd0, status_word(), {tag, "_status"});
    endtask

    // One batch. fixed<0 means random spin values per run. abort_at>0 drives
    // abort during that cycle. restart pulses start again (different params)
    // while busy. vote drives a 1,0,1 / 0,1,0 bit0 pattern across the sample.
    task automatic run_batch(input int nr, input int cm, input int fixed,
                             input int abort_at, input bit restart, input bit vote,
                             input string tag);
        int           cme;
        int           p;
        int           total;
        int           lim;
        int           ndone;
        bit           aborted;
        logic [N-1:0] vals [$];
        logic [N-1:0] v;
        cme     = (cm == 0) ? 1 : cm;
        p       = RSTC + cme + SL;
        total   = nr * p;
        aborted = (abort_at > 0);
        lim     = aborted ? abort_at + 2 : total + 2;
        hif.num_runs    = 32'(nr);
        hif.counter_max = 32'(cm);
        hif.start       = 1'b1;
        for (int t = 1; t <= lim; t++) begin
            bit e_busy;
            bit e_done;
            bit e_rstn;
            int ph;
            int k;
            tick();
            hif.start = 1'b0;
            hif.abort = 1'b0;
            e_busy = 1'b0;
            e_done = 1'b0;
            e_rstn = 1'b0;
            ph = (t - 1) % p;
            k  = (t - 1) / p;
            if (!(aborted && t > abort_at)) begin
                if (t <= total) begin
                    e_busy = 1'b1;
                    e_rstn = (ph >= RSTC);
                end else if (t == total + 1) begin
                    e_done = 1'b1;
                end
            end
            chk($sformatf("%s_busy_t%0d", tag, t), 32'(hif.busy), 32'(e_busy));
            chk($sformatf("%s_done_t%0d", tag, t), 32'(hif.done), 32'(e_done));
            chk($sformatf("%s_irstn_t%0d", tag, t), 32'(ising_rstn), 32'(e_rstn));
            if (t <= total && ph == 0) begin
                v = (fixed >= 0) ? N'(fixed) : N'($urandom);
                if (vote) v[0] = (k % 2 == 0);
                vals.push_back(v);
                outputs = v;
            end
            if (vote && t <= total) begin
                if (ph == p - 5) outputs[0] = (k % 2 == 0);
                if (ph == p - 4) outputs[0] = (k % 2 != 0);
                if (ph == p - 3) outputs[0] = (k % 2 == 0);
            end
            if (restart && t == 2) begin
                hif.start       = 1'b1;
                hif.num_runs    = 32'(nr + 3);
                hif.counter_max = 32'(cm + 5);
            end
            if (t == abort_at) hif.abort = 1'b1;
        end
        ndone = aborted ? (abort_at - 1) / p : nr;
        for (int i = 0; i < ndone; i++) begin
            m_buf[i % DEPTH]   = vals[i];
            m_valid[i % DEPTH] = 1'b1;
        end
        m_runs   = ndone;
        m_ovf    = (ndone > DEPTH);
        m_sticky = !aborted;
    endtask

    initial begin
        hif.start       = 1'b0;
        hif.abort       = 1'b0;
        hif.num_runs    = '0;
        hif.counter_max = '0;
        hif.rd_addr     = '0;
        for (int i = 0; i < DEPTH; i++) m_valid[i] = 1'b0;

        // Reset state
        repeat (3) tick();
        chk("rst_irstn", 32'(ising_rstn), 32'd0);
        chk("rst_busy",  32'(hif.busy),   32'd0);
        chk("rst_done",  32'(hif.done),   32'd0);
        chk("rst_rdata", hif.rdata,       32'd0);
        rstn = 1'b1;
        tick();
        rd(32'd0, 32'd0, "rst_status");

        // Constant 3'b101, two runs of ten cycles
        run_batch(2, 10, 5, 0, 1'b0, 1'b0, "t1");
        rd(32'd1, 32'd5, "t1_rd1");
        rd(32'd2, 32'd5, "t1_rd2");
        rd(32'd0, 32'h4000_0002, "t1_rd0");

        // Zero runs: straight to DONE
        run_batch(0, 7, -1, 0, 1'b0, 1'b0, "t2");
        rd(32'd0, 32'h4000_0000, "t2_rd0");

        // Buffer wrap and overflow
        run_batch(18, $urandom_range(0, 4), -1, 0, 1'b0, 1'b0, "t3");
        check_buf("t3");
        rd(32'd0, 32'h6000_0012, "t3_rd0");

        // Abort in the third cycle of the second run's RUN phase
        run_batch(3, 6, -1, (RSTC + 6 + SL) + RSTC + 3, 1'b0, 1'b0, "t4");
        rd(32'd0, 32'h0000_0001, "t4_rd0");
        check_buf("t4");
        run_batch(2, 3, -1, 0, 1'b0, 1'b0, "t4b");
        check_buf("t4b");

        // Restart ignored while busy; counter_max 0 gives a single RUN cycle
        run_batch(2, 0, -1, 0, 1'b1, 1'b0, "t5");
        check_buf("t5");

        // Random batches
        for (int b = 0; b < 3; b++) begin
            run_batch($urandom_range(1, 20), $urandom_range(0, 6), -1, 0, 1'b0, 1'b0,
                      $sformatf("rnd%0d", b));
            check_buf($sformatf("rnd%0d", b));
        end

`ifdef MAJORITY_VOTE_EN
        // Majority vote over the three sample captures
        run_batch(2, 3, -1, 0, 1'b0, 1'b1, "t6");
        check_buf("t6");
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

`default_nettype wire
